dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the internal data array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request accept and response, range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 srst  input  1  reset; synchronous, active-low (srst=0 sampled at a rising edge resets the block).
REQ-005 req_valid  input  1  core presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 req_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  core accepts the response.
REQ-014 rsp_rdata  output  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned, out of range or illegal size.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 Accept occurs on a cycle with req_valid=1 and req_ready=1; req_we, req_addr, req_wdata, req_size and req_unsigned are captured into registers at accept.
REQ-018 IDLE -> WAIT on accept when WAIT_CYCLES>0, loading a 4-bit wait counter with WAIT_CYCLES-1; IDLE -> RESP on accept when WAIT_CYCLES=0.
REQ-019 WAIT: counter decrements each cycle; WAIT -> RESP on the cycle the counter reads 0.
REQ-020 Response latency: rsp_valid asserts exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1; RESP -> IDLE on rsp_valid&&rsp_ready.
REQ-022 Requests are not accepted back-to-back with a pending response; at most one transaction is outstanding.
REQ-023 Word index = addr[31:2]; out of range when index >= DEPTH_WORDS.
REQ-024 Misaligned when size=01 and addr[0]=1, or size=10 and addr[1:0]!=0.
REQ-025 Error (misaligned, out of range, or size=11): array not modified, rsp_err=1, rsp_rdata=0.
REQ-026 Store commits to the array on the transition into RESP, using little-endian byte lanes selected by addr[1:0] and size; unselected bytes are unchanged.
REQ-027 Load data is read on the transition into RESP and is the selected byte/half/word shifted to bit 0, then extended per req_unsigned (word ignores req_unsigned).
REQ-028 Store response: rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-029 req_* inputs changing after accept have no effect on the in-flight transaction.

Reset
REQ-030 On reset: state IDLE, wait counter 0, req_ready=1 from the next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, all captured request registers 0.
REQ-031 On reset, all array words are cleared to 0.
REQ-032 Reset during WAIT or RESP abandons the transaction; a store not yet committed never writes, and no response is issued.
REQ-033 Reset takes priority over accept, counter decrement and response handshake in the same cycle.

Verification
REQ-034 Word store then load: store 0xDEADBEEF at 0x10, then load word 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, each rsp_valid 3 cycles after accept (WAIT_CYCLES=2).
REQ-035 Byte lanes: store byte 0x80 at 0x13 over 0x00000000, then load signed byte 0x13 -> 0xFFFFFF80; load unsigned byte 0x13 -> 0x00000080; load word 0x10 -> 0x80000000.
REQ-036 Misaligned and range: load half at 0x21 -> rsp_err=1, rsp_rdata=0; store word at 0x400 with DEPTH_WORDS=256 -> rsp_err=1 and a subsequent load of word 0 returns 0 (array unchanged).
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0; a req_valid pulse during that window is not accepted.
REQ-038 Reset mid-operation: accept a word store of 0x12345678 to 0x8, assert srst=0 during WAIT -> no response issued; after reset, a load of word 0x8 returns 0.
REQ-039 Zero wait: with WAIT_CYCLES=0, rsp_valid asserts 1 cycle after accept, and back-to-back transactions complete every 2 cycles with rsp_ready held at 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder for a core load/store port.
// One outstanding transaction at a time, fixed wait-state latency,
// byte/half/word access with little-endian lanes and error detection.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready to accept a request (req_ready=1)
// WAIT   | request captured, counting down the wait states
// RESP   | response presented, held until rsp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [1:0]       cur_size;
    logic             cur_uns;
    logic             bad_size;
    logic             misaligned;
    logic             out_of_range;
    logic             txn_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      word_old;
    logic [31:0]      lane_mask;
    logic [31:0]      lane_data;
    logic [31:0]      load_shift;
    logic [31:0]      load_val;
    logic             mem_wr_en;
    logic [31:0]      mem_wr_word;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

    // Request seen by the datapath: live inputs while idle (needed when the
    // zero-wait configuration enters RESP on the accept edge), captured copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_size  = req_size;
            cur_uns   = req_unsigned;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
            cur_uns   = uns_q;
        end
    end

    // Error classification and word lookup for the current request.
    always_comb begin
        bad_size     = (cur_size == 2'b11);
        misaligned   = ((cur_size == 2'b01) && cur_addr[0]) ||
                       ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
        txn_err      = bad_size || misaligned || out_of_range;
        word_idx     = cur_addr[IDX_W+1:2];
        word_old     = out_of_range ? 32'd0 : mem_q[word_idx];
    end

    // Store lane merge and load extraction/extension.
    always_comb begin
        lane_mask  = 32'd0;
        lane_data  = 32'd0;
        load_val   = 32'd0;
        load_shift = word_old >> {cur_addr[1:0], 3'b000};
        case (cur_size)
            2'b00: begin
                lane_mask = 32'h0000_00FF << {cur_addr[1:0], 3'b000};
                lane_data = {24'd0, cur_wdata[7:0]} << {cur_addr[1:0], 3'b000};
                load_val  = cur_uns ? {24'd0, load_shift[7:0]}
                                    : {{24{load_shift[7]}}, load_shift[7:0]};
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF << {cur_addr[1], 4'b0000};
                lane_data = {16'd0, cur_wdata[15:0]} << {cur_addr[1], 4'b0000};
                load_val  = cur_uns ? {16'd0, load_shift[15:0]}
                                    : {{16{load_shift[15]}}, load_shift[15:0]};
            end
            2'b10: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = cur_wdata;
                load_val  = word_old;
            end
            default: begin
                lane_mask = 32'd0;
                lane_data = 32'd0;
                load_val  = 32'd0;
            end
        endcase
        mem_wr_word = (word_old & ~lane_mask) | (lane_data & lane_mask);
    end

    // Next-state, capture, wait counter and response registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (enter_resp) begin
            err_d   = txn_err;
            rdata_d = (txn_err || cur_we) ? 32'd0 : load_val;
        end
        mem_wr_en = enter_resp && cur_we && !txn_err;
    end

    // Control and capture registers; reset wins over every other update.
    always_ff @(posedge clk) begin
        if (!srst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Data array: cleared on reset, one merged word written on store commit.
    always_ff @(posedge clk) begin
        if (!srst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_wr_en) begin
            mem_q[word_idx] <= mem_wr_word;
        end
    end

endmodule
